// File: rtl/vending_change_dispenser.sv
// vending_change_dispenser: greedy 100/50/20/10 change payout to a coin hopper over valid/ready.
// Define VENDING_CHANGE_INVENTORY_EN to track per-denomination coin stock with refill and coins_low.
module vending_change_dispenser #(
    parameter int AMT_W      = 8,
    parameter int CNT_W      = 8,
    parameter int INIT_COUNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change_req,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             hopper_ready,
    input  logic             refill,
    output logic             coin_valid,
    output logic [AMT_W-1:0] coin_out,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic             coins_low
);
    typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, DONE} state_t;
    localparam logic [AMT_W-1:0] D100 = AMT_W'(100);
    localparam logic [AMT_W-1:0] D50  = AMT_W'(50);
    localparam logic [AMT_W-1:0] D20  = AMT_W'(20);
    localparam logic [AMT_W-1:0] D10  = AMT_W'(10);
    state_t state, state_nxt;
    logic [AMT_W-1:0] remaining, pick;
    logic [3:0] avail, fit, cand;
    logic [1:0] pick_idx;
    logic found;
    // Index 0..3 maps to 100, 50, 20, 10; lowest candidate index is the largest coin.
    assign fit      = {remaining >= D10, remaining >= D20, remaining >= D50, remaining >= D100};
    assign cand     = fit & avail;
    assign found    = |cand;
    assign pick_idx = cand[0] ? 2'd0 : cand[1] ? 2'd1 : cand[2] ? 2'd2 : 2'd3;
    assign pick     = pick_idx == 2'd0 ? D100 : pick_idx == 2'd1 ? D50 : pick_idx == 2'd2 ? D20 : D10;
`ifdef VENDING_CHANGE_INVENTORY_EN
    logic [CNT_W-1:0] cnt [4];
    logic [1:0] coin_idx;
    assign avail     = {cnt[3] != '0, cnt[2] != '0, cnt[1] != '0, cnt[0] != '0};
    assign coins_low = ~&avail;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= CNT_W'(INIT_COUNT);
            coin_idx <= 2'd0;
        end else begin
            if (state == SELECT) coin_idx <= pick_idx;
            if (state == IDLE && refill)
                for (int i = 0; i < 4; i++) cnt[i] <= CNT_W'(INIT_COUNT);
            else if (state == DISPENSE && hopper_ready)
                cnt[coin_idx] <= cnt[coin_idx] - CNT_W'(1);
        end
    end
`else
    logic unused_inventory;
    assign unused_inventory = refill | (CNT_W'(INIT_COUNT) == '0);
    assign avail            = 4'hf;
    assign coins_low        = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE     ? (change_req ? SELECT : IDLE) :
                    state == SELECT   ? (found ? DISPENSE : DONE) :
                    state == DISPENSE ? (hopper_ready ? SELECT : DISPENSE) :
                                        IDLE;
    end
    always_comb begin
        coin_valid = state == DISPENSE;
        busy       = state != IDLE;
        done       = state == DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            coin_out  <= '0;
            shortfall <= '0;
        end else if (state == IDLE && change_req) begin
            remaining <= change_amt;
            shortfall <= '0;
        end else if (state == SELECT) begin
            if (found) coin_out <= pick;
            else       shortfall <= remaining;
        end else if (state == DISPENSE && hopper_ready) begin
            remaining <= remaining - coin_out;
        end
    end
endmodule

// File: tb/tb_vending_change_dispenser.sv
// tb_vending_change_dispenser: randomized requests and hopper stalls checked against a greedy change model.
module tb_vending_change_dispenser;
    localparam int AMT_W = 8;
`ifdef VENDING_CHANGE_INVENTORY_EN
    localparam int INIT   = 1;
    localparam bit INV_EN = 1'b1;
`else
    localparam int INIT   = 16;
    localparam bit INV_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, change_req, hopper_ready, refill, coin_valid, busy, done, coins_low;
    logic [AMT_W-1:0] change_amt, coin_out, shortfall;
    int n_tests = 0;
    int n_fail = 0;
    int den[4] = '{100, 50, 20, 10};
    int inv[4];
    int exp_q[$];

    always #5 clk = ~clk;

    vending_change_dispenser #(.AMT_W(AMT_W), .CNT_W(8), .INIT_COUNT(INIT)) dut (
        .clk(clk), .rst(rst), .change_req(change_req), .change_amt(change_amt),
        .hopper_ready(hopper_ready), .refill(refill), .coin_valid(coin_valid),
        .coin_out(coin_out), .busy(busy), .done(done), .shortfall(shortfall),
        .coins_low(coins_low)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Greedy payout plan: largest coin not above the remainder and still in stock.
    task automatic plan(input int amt, output int sf);
        int rem;
        bit found;
        rem = amt;
        exp_q.delete();
        do begin
            found = 1'b0;
            for (int i = 0; i < 4; i++)
                if (!found && rem >= den[i] && (!INV_EN || inv[i] > 0)) begin
                    exp_q.push_back(den[i]);
                    rem -= den[i];
                    if (INV_EN) inv[i]--;
                    found = 1'b1;
                end
        end while (found);
        sf = rem;
    endtask

    function automatic bit model_low();
        model_low = 1'b0;
        for (int i = 0; i < 4; i++) if (INV_EN && inv[i] == 0) model_low = 1'b1;
    endfunction

    task automatic restock();
        for (int i = 0; i < 4; i++) inv[i] = INIT;
    endtask

    task automatic request(input int amt, input int rdy_pct, input int stall);
        int sf, n_exp, hs, last_acc, first_v;
        bit fin;
        hs = 0; last_acc = -10; first_v = -1; fin = 1'b0;
        plan(amt, sf);
        n_exp = exp_q.size();
        @(posedge clk); #1;
        change_req = 1'b1;
        change_amt = amt[AMT_W-1:0];
        hopper_ready = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(posedge clk); #1;
            change_req   = busy && $urandom_range(3) == 0;
            change_amt   = AMT_W'($urandom);
            hopper_ready = stall > 0 ? 1'b0 : $urandom_range(99) < rdy_pct;
            @(negedge clk);
            check("busy", busy, 1);
            if (coin_valid) begin
                if (first_v < 0) begin
                    first_v = c;
                    check("first_coin_lat", c, 1);
                end
                check("coin_out", coin_out, exp_q.size() > 0 ? exp_q[0] : 0);
                if (hopper_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    hs++;
                    last_acc = c;
                end else if (stall > 0) stall--;
            end
            if (done) begin
                fin = 1'b1;
                check("shortfall", shortfall, sf);
                check("handshakes", hs, n_exp);
                check("done_lat", c, n_exp > 0 ? last_acc + 2 : 1);
            end
        end
        change_req = 1'b0;
        hopper_ready = 1'b0;
        if (!fin) check("timeout", 0, 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("done_pulse", done, 0);
        check("sf_hold", shortfall, sf);
        check("coins_low", coins_low, model_low());
    endtask

    task automatic do_refill();
        @(posedge clk); #1;
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
        restock();
        check("refill_low", coins_low, 0);
    endtask

    task automatic reset_mid();
        @(posedge clk); #1;
        change_req = 1'b1;
        change_amt = 8'd100;
        hopper_ready = 1'b0;
        @(posedge clk); #1;
        change_req = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", coin_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", coin_valid, 0);
        check("rst_async_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        restock();
        check("rst_coins_low", coins_low, 0);
    endtask

    initial begin
        rst = 1'b1; change_req = 1'b0; change_amt = '0; hopper_ready = 1'b0; refill = 1'b0;
        restock();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", coin_valid, 0);
        check("rst_coin", coin_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sf", shortfall, 0);
        check("rst_low", coins_low, 0);
        @(negedge clk);
        rst = 1'b0;
        request(70, 100, 0);
        request(180, 100, 0);
        request(255, 100, 0);
        request(0, 100, 0);
        request(30, 100, 3);
`ifdef VENDING_CHANGE_INVENTORY_EN
        do_refill();
        request(30, 100, 0);
        request(30, 100, 0);
        do_refill();
        request(30, 100, 0);
`endif
        reset_mid();
        request(180, 100, 0);
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(3) == 0) do_refill();
            request($urandom_range(255), $urandom_range(100, 30), $urandom_range(2));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
